// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Field extraction is width-generic up to BUS_MAX/FLD_MAX bits.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  localparam bit B_WINS = 1'b1;

  localparam int BUS_MAX = 512;
  localparam int FLD_MAX = 128;

  function automatic logic [FLD_MAX-1:0] field(
    input logic [BUS_MAX-1:0] bus,
    input int                 k,
    input int                 w
  );
    logic [FLD_MAX-1:0] m;
    m = (w >= FLD_MAX) ? '1 :
        ((FLD_MAX'(1) << w) - FLD_MAX'(1));
    return FLD_MAX'(bus >> (k * w)) & m;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/scoreboard/debug bus of the register file.
// Master is the datapath side, slave is the register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output sb_set, sb_addr, dbg_addr,
    input  rd_data, rd_busy, dbg_data
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  sb_set, sb_addr, dbg_addr,
    output rd_data, rd_busy, dbg_data
  );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits for issue-stage hazard detection.
// Set beats clear; a register being written reads as not busy.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wa_en) busy_d[wa_addr] = 1'b0;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (sb_set) busy_d[sb_addr] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              wr_hit;
    assign a = ADDR_W'(field(BUS_MAX'(rd_addr), k, ADDR_W));
    assign wr_hit = (wa_en && wa_addr == a) ||
                    (wb_en && wb_addr == a);
    assign rd_busy[k] = busy_q[a] & ~wr_hit;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with write bypass,
// optional zero register, busy scoreboard and a debug tap.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          NUM_RD    = NUM_RD_DEF,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter bit          ZERO_REG  = 1'b1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DATA_W-1:0] RST_V = DATA_W'(RESET_VAL);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] dbg_q;
  logic              wa_ok;
  logic              wb_ok;

  function automatic logic is_z(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Losing port is squashed here so storage and bypass agree.
  always_comb begin
    wa_ok = bus.wa_en && !is_z(bus.wa_addr);
    wb_ok = bus.wb_en && !is_z(bus.wb_addr);
    if (bus.wa_addr == bus.wb_addr) begin
      if (B_WINS) wa_ok = wa_ok && !wb_ok;
      else        wb_ok = wb_ok && !wa_ok;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (ZERO_REG && i == 0) ? '0 : RST_V;
      dbg_q <= '0;
    end else begin
      dbg_q <= regs_q[bus.dbg_addr];
      if (wa_ok) regs_q[bus.wa_addr] <= bus.wa_data;
      if (wb_ok) regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.dbg_data = dbg_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = ADDR_W'(field(BUS_MAX'(bus.rd_addr), k, ADDR_W));
    always_comb begin
      d = regs_q[a];
      unique case (1'b1)
        is_z(a):                    d = '0;
        wb_ok && bus.wb_addr == a: d = bus.wb_data;
        wa_ok && bus.wa_addr == a: d = bus.wa_data;
        default:                    d = regs_q[a];
      endcase
    end
    assign bus.rd_data[k*DATA_W +: DATA_W] = d;
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .wa_en   (bus.wa_en),
    .wa_addr (bus.wa_addr),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .sb_set  (bus.sb_set),
    .sb_addr (bus.sb_addr),
    .rd_addr (bus.rd_addr),
    .rd_busy (bus.rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp against an array-based model.
// Expected outputs are queued per cycle and checked by a monitor.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp_if #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) bus ();

  reg_file_mp #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_RD    (NR),
    .RESET_VAL (32'h1),
    .ZERO_REG  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NR-1:0][DW-1:0] d;
    logic [NR-1:0]         b;
    logic [DW-1:0]         dbg;
  } exp_t;

  exp_t        q[$];
  logic [DW-1:0] mem [32];
  bit          busy [32];
  logic [DW-1:0] exp_dbg;
  int          tests = 0;
  int          fails = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = (i == 0) ? 32'h0 : 32'h1;
      busy[i] = 1'b0;
    end
    exp_dbg = '0;
  endtask

  // Predict this cycle's outputs, then advance the model
  // to the state after the coming edge (if not in reset).
  task automatic step();
    exp_t        e;
    logic [AW-1:0] a;
    bit          hit;
    for (int k = 0; k < NR; k++) begin
      a = bus.rd_addr[k*AW +: AW];
      hit = (bus.wa_en && bus.wa_addr == a) ||
            (bus.wb_en && bus.wb_addr == a);
      if (a == 0)
        e.d[k] = '0;
      else if (bus.wb_en && bus.wb_addr == a)
        e.d[k] = bus.wb_data;
      else if (bus.wa_en && bus.wa_addr == a)
        e.d[k] = bus.wa_data;
      else
        e.d[k] = mem[a];
      e.b[k] = (a != 0) && busy[a] && !hit;
    end
    e.dbg = exp_dbg;
    q.push_back(e);
    if (rst) begin
      exp_dbg = mem[bus.dbg_addr];
      if (bus.wa_en) begin
        busy[bus.wa_addr] = 1'b0;
        if (bus.wa_addr != 0) mem[bus.wa_addr] = bus.wa_data;
      end
      if (bus.wb_en) begin
        busy[bus.wb_addr] = 1'b0;
        if (bus.wb_addr != 0) mem[bus.wb_addr] = bus.wb_data;
      end
      if (bus.sb_set && bus.sb_addr != 0)
        busy[bus.sb_addr] = 1'b1;
    end
  endtask

  task automatic cyc(
    input logic          r,
    input logic          wae,
    input logic [AW-1:0] waa,
    input logic [DW-1:0] wad,
    input logic          wbe,
    input logic [AW-1:0] wba,
    input logic [DW-1:0] wbd,
    input logic          sbs,
    input logic [AW-1:0] sba,
    input logic [AW-1:0] r0,
    input logic [AW-1:0] r1,
    input logic [AW-1:0] dba
  );
    @(negedge clk);
    rst          = r;
    bus.wa_en    = wae;
    bus.wa_addr  = waa;
    bus.wa_data  = wad;
    bus.wb_en    = wbe;
    bus.wb_addr  = wba;
    bus.wb_data  = wbd;
    bus.sb_set   = sbs;
    bus.sb_addr  = sba;
    bus.rd_addr  = {r1, r0};
    bus.dbg_addr = dba;
    step();
  endtask

  task automatic idle(input logic [AW-1:0] r0,
                      input logic [AW-1:0] r1,
                      input logic [AW-1:0] dba);
    cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, dba);
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  // Monitor: samples combinational and registered outputs
  // between the driving negedge and the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < NR; k++) begin
          tests++;
          if (bus.rd_data[k*DW +: DW] !== e.d[k]) begin
            fails++;
            $display("FAIL rd_data%0d t=%0t: got %h expected %h",
                     k, $time, bus.rd_data[k*DW +: DW], e.d[k]);
          end
          tests++;
          if (bus.rd_busy[k] !== e.b[k]) begin
            fails++;
            $display("FAIL rd_busy%0d t=%0t: got %b expected %b",
                     k, $time, bus.rd_busy[k], e.b[k]);
          end
        end
        tests++;
        if (bus.dbg_data !== e.dbg) begin
          fails++;
          $display("FAIL dbg_data t=%0t: got %h expected %h",
                   $time, bus.dbg_data, e.dbg);
        end
      end
    end
  end

  initial begin
    bus.wa_en = 0; bus.wa_addr = 0; bus.wa_data = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.sb_set = 0; bus.sb_addr = 0;
    bus.rd_addr = '0; bus.dbg_addr = 0;
    model_reset();

    idle(0, 6, 0);
    idle(0, 6, 6);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 6);

    cyc(1, 1, 6, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 6, 0, 6);
    idle(6, 6, 6);
    idle(6, 0, 6);

    cyc(1, 1, 9, 32'h11, 1, 9, 32'h22, 0, 0, 9, 9, 9);
    idle(9, 9, 9);

    cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 5, 5, 0);
    idle(5, 5, 0);
    cyc(1, 0, 0, 0, 1, 5, 32'h55, 0, 0, 5, 5, 0);
    idle(5, 5, 5);

    cyc(1, 1, 7, 32'h77, 0, 0, 0, 1, 7, 7, 7, 0);
    idle(7, 7, 7);

    cyc(1, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 0, 0);

    for (int i = 0; i < 150; i++)
      cyc(1, 1'($urandom), raddr(), $urandom,
          1'($urandom), raddr(), $urandom,
          1'($urandom), raddr(),
          raddr(), raddr(), raddr());

    cyc(1, 1, 3, 32'hAAAA, 1, 7, 32'hBBBB, 1, 3, 3, 7, 3);
    #4;
    rst = 1'b0;
    model_reset();
    idle(3, 7, 3);
    idle(0, 7, 7);
    cyc(1, 1, 3, 32'h5555, 0, 0, 0, 0, 0, 3, 7, 3);
    idle(3, 7, 3);

    for (int i = 0; i < 150; i++)
      cyc(1, 1'($urandom), raddr(), $urandom,
          1'($urandom), raddr(), $urandom,
          1'($urandom), raddr(),
          raddr(), raddr(), raddr());

    @(negedge clk);
    #4;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
